uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Asynchronous serial receiver: 8N1 frames on a single input wire are converted to parallel bytes.
- Sits on the receive side of the UART, directly downstream of the serial line driven by the UART transmitter. Used for loopback against it and for host links.
- Delivers each byte over a valid/ready handshake to the consuming logic.
- Self-contained bit timing; no external clock divider.

Parameters:
- CLOCK_FREQUENCY, 1_000_000, Clk frequency in Hz.
- BAUD_RATE, 9600, line rate in bit/s.
- BIT_CYCLES, (CLOCK_FREQUENCY + BAUD_RATE/2) / BAUD_RATE, Clk cycles per bit (104 at defaults). Legal range 8..65535.
- HALF_CYCLES, BIT_CYCLES / 2, cycles from the start edge to mid-bit (52 at defaults).

Ports:
- Clk  input  1  system clock; all logic on posedge.
- Reset  input  1  asynchronous, active-low reset (negedge Reset).
- RxWire  input  1  serial line; idles high; asynchronous to Clk.
- RxDataOutput  output  8  received byte; stable while RxValid=1.
- RxValid  output  1  byte available; held until accepted.
- RxReady  input  1  consumer accepts the byte when RxValid & RxReady at posedge.
- RxFrameError  output  1  one-cycle pulse: stop bit sampled low.
- RxOverrun  output  1  one-cycle pulse: byte completed while RxValid still 1.
- RxBusy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset values (asynchronous):
  - state = IDLE; synchronizer flops = 1; bit counter = 0; cycle counter = 0.
  - RxDataOutput = 8'h00; RxValid = 0; RxFrameError = 0; RxOverrun = 0; RxBusy = 0.
- Input synchronization:
  - RxWire passes through a 2-flop synchronizer; the result is "rxs".
  - The previous rxs value is kept for edge detection.
  - Total input latency: 2 cycles.
- Sampling:
  - The cycle counter runs from 0 to BIT_CYCLES-1 in every non-IDLE state and wraps to 0.
  - A bit value is the 2-of-3 majority of rxs at counts HALF_CYCLES-1, HALF_CYCLES and HALF_CYCLES+1.
  - The bit decision is taken at count HALF_CYCLES+1.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - A falling edge on rxs (prev=1, now=0) moves to START with counter = 0.
- START:
  - At the decision point, majority 1 is a false start: return to IDLE with no outputs changed.
  - Majority 0: continue. On counter wrap, move to DATA with bit index = 0.
- DATA:
  - At each decision point the bit is shifted into the shift register LSB-first (the new bit enters at [7], shift right).
  - On wrap: if bit index = 7, move to STOP; otherwise increment the index (3-bit).
- STOP, at the decision point:
  - Majority 1 and RxValid=0: RxDataOutput <= shift register, RxValid <= 1 on the next edge, return to IDLE.
    - Return happens at the decision point, not at wrap, to tolerate clock skew.
    - Latency from the true mid-stop-bit to RxValid: 2 (sync) + 2 (majority window) + 1 = 5 cycles.
  - Majority 1 and RxValid=1 and no acceptance this cycle: RxOverrun pulses for 1 cycle.
    - The new byte is discarded; the old RxDataOutput and RxValid are retained. Return to IDLE.
  - Majority 1 and RxValid=1 with RxValid&RxReady this same cycle: the acceptance wins.
    - The new byte is loaded and RxValid stays 1. No overrun.
  - Majority 0: RxFrameError pulses for 1 cycle, the byte is discarded, move to BREAK.
- BREAK:
  - Wait until rxs = 1 for one full BIT_CYCLES window (counter restarts at 0 on any rxs=0), then go to IDLE.
  - A held-low line therefore produces exactly one RxFrameError.
- Handshake:
  - RxValid clears on the posedge where RxValid & RxReady, except in the simultaneous-load case above.
  - RxReady while RxValid=0 has no effect.
- Reset mid-frame: immediate return to the reset values. A partial byte is never delivered.
- RxWire glitches shorter than 1 cycle of rxs at the decision window do not change the bit value (majority vote).

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1. A PARITY state is inserted between DATA and STOP and sampled with the same majority scheme.
  - Parity mismatch against even parity of the data bits: output RxParityError (1 bit) pulses 1 cycle at the STOP decision and the byte is discarded.
  - Parity mismatch plus bad stop: only RxFrameError is raised.
- Undefined: frame is 8N1; the RxParityError port does not exist.

Test Plan:
- Reset, then drive the 8N1 frame for 8'hA5 at 104 cycles/bit, RxReady=0 -> RxValid rises 5 cycles after mid-stop, RxDataOutput=8'hA5, held until RxReady=1 for one cycle, then RxValid=0.
- Low pulse of 30 cycles on an idle line -> false start; RxValid, RxFrameError and RxBusy return to 0/IDLE within 60 cycles; the following frame 8'h3C is received correctly.
- Frame 8'h55 with the stop bit driven low, then line held low for 500 cycles -> exactly one RxFrameError pulse; no RxValid; frame 8'h81 sent after the line returns high is received.
- Two back-to-back frames 8'h11, 8'h22 with RxReady=0 -> RxDataOutput stays 8'h11 and one RxOverrun pulse occurs. Repeat with RxReady=1 pulsed in the second frame's stop decision cycle -> 8'h22 delivered, no overrun.
- Bit periods of 100 and 108 cycles (±4%), frames 8'h00 and 8'hFF -> both received without error.
- Assert Reset during DATA bit 4 of frame 8'hF0, release, then send 8'h0F -> only 8'h0F is ever presented. With UART_RX_PARITY_EN, 8'h07 sent with parity bit 0 -> RxParityError pulse and no RxValid.

Source files
------------

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// uart_rx: asynchronous 8N1 serial receiver with 2-of-3 mid-bit majority sampling and a valid/ready byte port.
// Defining UART_RX_PARITY_EN switches the frame to 8E1 and adds the RxParityError pulse output.
module uart_rx #(
   parameter int CLOCK_FREQUENCY = 1_000_000,
   parameter int BAUD_RATE       = 9600,
   parameter int BIT_CYCLES      = (CLOCK_FREQUENCY + BAUD_RATE / 2) / BAUD_RATE,
   parameter int HALF_CYCLES     = BIT_CYCLES / 2
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       RxWire,
   output logic [7:0] RxDataOutput,
   output logic       RxValid,
   input  logic       RxReady,
   output logic       RxFrameError,
   output logic       RxOverrun,
`ifdef UART_RX_PARITY_EN
   output logic       RxParityError,
`endif
   output logic       RxBusy
);

   localparam logic [15:0] LAST_COUNT  = 16'(BIT_CYCLES - 1);
   localparam logic [15:0] SAMPLE0     = 16'(HALF_CYCLES - 1);
   localparam logic [15:0] SAMPLE1     = 16'(HALF_CYCLES);
   localparam logic [15:0] DECIDE      = 16'(HALF_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_BREAK  = 3'd5
   } state_t;

   state_t      state, state_n;
   logic        sync1, rxs, rxs_prev;
   logic [15:0] cnt, cnt_n;
   logic [2:0]  bit_idx, bit_idx_n;
   logic [7:0]  shift, shift_n;
   logic [1:0]  samp, samp_n;
   logic [7:0]  data_n;
   logic        valid_n;
   logic        frame_err_n;
   logic        overrun_n;
   logic        busy_n;
   logic        maj;
   logic        at_wrap;
   logic        at_decide;
   logic        accept;
`ifdef UART_RX_PARITY_EN
   logic        par_bit, par_bit_n;
   logic        par_err_n;
`endif

   assign maj       = (samp[0] & samp[1]) | (samp[0] & rxs) | (samp[1] & rxs);
   assign at_wrap   = (cnt == LAST_COUNT);
   assign at_decide = (cnt == DECIDE);
   assign accept    = RxValid & RxReady;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         sync1        <= 1'b1;
         rxs          <= 1'b1;
         rxs_prev     <= 1'b1;
         state        <= S_IDLE;
         cnt          <= 16'd0;
         bit_idx      <= 3'd0;
         shift        <= 8'h00;
         samp         <= 2'b11;
         RxDataOutput <= 8'h00;
         RxValid      <= 1'b0;
         RxFrameError <= 1'b0;
         RxOverrun    <= 1'b0;
         RxBusy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit       <= 1'b0;
         RxParityError <= 1'b0;
`endif
      end else begin
         sync1        <= RxWire;
         rxs          <= sync1;
         rxs_prev     <= rxs;
         state        <= state_n;
         cnt          <= cnt_n;
         bit_idx      <= bit_idx_n;
         shift        <= shift_n;
         samp         <= samp_n;
         RxDataOutput <= data_n;
         RxValid      <= valid_n;
         RxFrameError <= frame_err_n;
         RxOverrun    <= overrun_n;
         RxBusy       <= busy_n;
`ifdef UART_RX_PARITY_EN
         par_bit       <= par_bit_n;
         RxParityError <= par_err_n;
`endif
      end
   end

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      bit_idx_n   = bit_idx;
      shift_n     = shift;
      samp_n      = samp;
      data_n      = RxDataOutput;
      valid_n     = RxValid;
      frame_err_n = 1'b0;
      overrun_n   = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_n   = par_bit;
      par_err_n   = 1'b0;
`endif

      if (accept) begin
         valid_n = 1'b0;
      end

      if (state != S_IDLE) begin
         cnt_n = at_wrap ? 16'd0 : cnt + 16'd1;
      end
      if (cnt == SAMPLE0) begin
         samp_n[0] = rxs;
      end
      if (cnt == SAMPLE1) begin
         samp_n[1] = rxs;
      end

      case (state)
         S_IDLE: begin
            cnt_n = 16'd0;
            if (rxs_prev && !rxs) begin
               state_n = S_START;
            end
         end
         S_START: begin
            if (at_decide && maj) begin
               state_n = S_IDLE;
               cnt_n   = 16'd0;
            end else if (at_wrap) begin
               state_n   = S_DATA;
               bit_idx_n = 3'd0;
            end
         end
         S_DATA: begin
            if (at_decide) begin
               shift_n = {maj, shift[7:1]};
            end
            if (at_wrap) begin
               if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_n = S_PARITY;
`else
                  state_n = S_STOP;
`endif
               end else begin
                  bit_idx_n = bit_idx + 3'd1;
               end
            end
         end
         S_PARITY: begin
`ifdef UART_RX_PARITY_EN
            if (at_decide) begin
               par_bit_n = maj;
            end
`endif
            if (at_wrap) begin
               state_n = S_STOP;
            end
         end
         S_STOP: begin
            // Leave at the decision point rather than at wrap so a fast
            // transmitter's next start edge is never missed.
            if (at_decide) begin
               cnt_n = 16'd0;
               if (!maj) begin
                  frame_err_n = 1'b1;
                  state_n     = S_BREAK;
               end else begin
                  state_n = S_IDLE;
`ifdef UART_RX_PARITY_EN
                  if ((^shift) != par_bit) begin
                     par_err_n = 1'b1;
                  end else
`endif
                  if (!RxValid || accept) begin
                     data_n  = shift;
                     valid_n = 1'b1;
                  end else begin
                     overrun_n = 1'b1;
                  end
               end
            end
         end
         S_BREAK: begin
            if (!rxs) begin
               cnt_n = 16'd0;
            end else if (at_wrap) begin
               state_n = S_IDLE;
               cnt_n   = 16'd0;
            end
         end
         default: begin
            state_n = S_IDLE;
            cnt_n   = 16'd0;
         end
      endcase

      busy_n = (state_n != S_IDLE);
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// tb_uart_rx: directed self-checking bench for uart_rx at the default 104 cycles/bit.
module tb_uart_rx;

   logic       Clk;
   logic       Reset;
   logic       RxWire;
   logic [7:0] RxDataOutput;
   logic       RxValid;
   logic       RxReady;
   logic       RxFrameError;
   logic       RxOverrun;
   logic       RxBusy;
`ifdef UART_RX_PARITY_EN
   logic       RxParityError;
`endif

   int passed = 0;
   int total  = 0;

   int         fe_cnt   = 0;
   int         ov_cnt   = 0;
   int         pe_cnt   = 0;
   int         rise_cnt = 0;
   logic       valid_q  = 1'b0;

   uart_rx dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .RxWire       (RxWire),
      .RxDataOutput (RxDataOutput),
      .RxValid      (RxValid),
      .RxReady      (RxReady),
      .RxFrameError (RxFrameError),
      .RxOverrun    (RxOverrun),
`ifdef UART_RX_PARITY_EN
      .RxParityError(RxParityError),
`endif
      .RxBusy       (RxBusy)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Pulse and presentation counters, sampled mid-cycle.
   always @(negedge Clk) begin
      if (RxFrameError) fe_cnt++;
      if (RxOverrun) ov_cnt++;
`ifdef UART_RX_PARITY_EN
      if (RxParityError) pe_cnt++;
`endif
      if (RxValid && !valid_q) rise_cnt++;
      valid_q = RxValid;
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) begin passed++; end
      else $error("FAIL %s: observed %b required %b", tag, obs, exp);
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) begin passed++; end
      else $error("FAIL %s: observed %h required %h", tag, obs, exp);
   endtask

   task automatic chkn(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) begin passed++; end
      else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
   endtask

   // Called and returns on a negedge.
   task automatic drive_bit(input logic v, input int p);
      RxWire = v;
      repeat (p) @(negedge Clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input int p, input logic stop, input logic par_good);
      drive_bit(1'b0, p);
      for (int i = 0; i < 8; i++) drive_bit(b[i], p);
`ifdef UART_RX_PARITY_EN
      drive_bit(par_good ? ^b : ~^b, p);
`else
      if (par_good) begin end
`endif
      drive_bit(stop, p);
   endtask

   task automatic ack();
      @(negedge Clk) RxReady = 1'b1;
      @(negedge Clk) RxReady = 1'b0;
   endtask

   int         f0, r0, o0;
   logic [7:0] b;
   int         periods [2] = '{100, 108};
   logic [7:0] pbytes  [2] = '{8'h00, 8'hFF};

   initial begin
      Reset   = 1'b0;
      RxWire  = 1'b1;
      RxReady = 1'b0;
      repeat (3) @(negedge Clk);
      chk1("rst_valid", RxValid, 1'b0);
      chk8("rst_data", RxDataOutput, 8'h00);
      chk1("rst_busy", RxBusy, 1'b0);
      chk1("rst_fe", RxFrameError, 1'b0);
      chk1("rst_ov", RxOverrun, 1'b0);
      Reset = 1'b1;
      repeat (10) @(negedge Clk);

      // 8'hA5: start edge at negedge tn, mid-stop at tn + 9.5 bits (a negedge);
      // RxValid must be low after the 4th and high after the 5th posedge after it.
      b = 8'hA5;
      drive_bit(1'b0, 104);
      for (int i = 0; i < 8; i++) drive_bit(b[i], 104);
`ifdef UART_RX_PARITY_EN
      drive_bit(^b, 104);
`endif
      RxWire = 1'b1;
      repeat (52) @(negedge Clk);
      repeat (4) @(posedge Clk);
      #1 chk1("a5_valid_early", RxValid, 1'b0);
      @(posedge Clk);
      #1 chk1("a5_valid_on_time", RxValid, 1'b1);
      chk8("a5_data", RxDataOutput, 8'hA5);
      repeat (200) @(negedge Clk);
      chk1("a5_valid_held", RxValid, 1'b1);
      chk8("a5_data_held", RxDataOutput, 8'hA5);
      ack();
      chk1("a5_valid_cleared", RxValid, 1'b0);

      // False start: 30-cycle low pulse.
      f0 = fe_cnt; r0 = rise_cnt;
      repeat (20) @(negedge Clk);
      RxWire = 1'b0;
      repeat (20) @(negedge Clk);
      chk1("fs_busy_start", RxBusy, 1'b1);
      repeat (10) @(negedge Clk);
      RxWire = 1'b1;
      repeat (30) @(negedge Clk);
      chk1("fs_busy_idle", RxBusy, 1'b0);
      chk1("fs_no_valid", RxValid, 1'b0);
      chkn("fs_no_fe", fe_cnt, f0);
      repeat (100) @(negedge Clk);
      send_frame(8'h3C, 104, 1'b1, 1'b1);
      chk1("3c_valid", RxValid, 1'b1);
      chk8("3c_data", RxDataOutput, 8'h3C);
      chkn("3c_one_rise", rise_cnt, r0 + 1);
      ack();

      // Bad stop bit then a 500-cycle break.
      f0 = fe_cnt; r0 = rise_cnt;
      repeat (50) @(negedge Clk);
      send_frame(8'h55, 104, 1'b0, 1'b1);
      repeat (500) @(negedge Clk);
      RxWire = 1'b1;
      repeat (250) @(negedge Clk);
      chkn("brk_one_fe", fe_cnt, f0 + 1);
      chkn("brk_no_valid", rise_cnt, r0);
      chk1("brk_idle", RxBusy, 1'b0);
      send_frame(8'h81, 104, 1'b1, 1'b1);
      chk1("81_valid", RxValid, 1'b1);
      chk8("81_data", RxDataOutput, 8'h81);
      ack();

      // Back-to-back frames, no acceptance: overrun, old byte kept.
      o0 = ov_cnt;
      repeat (50) @(negedge Clk);
      send_frame(8'h11, 104, 1'b1, 1'b1);
      send_frame(8'h22, 104, 1'b1, 1'b1);
      chk1("ov_valid", RxValid, 1'b1);
      chk8("ov_data_kept", RxDataOutput, 8'h11);
      chkn("ov_one_pulse", ov_cnt, o0 + 1);
      ack();

      // Same again with acceptance exactly at the second stop decision
      // (57th posedge after the stop bit begins on the line).
      o0 = ov_cnt;
      repeat (50) @(negedge Clk);
      send_frame(8'h11, 104, 1'b1, 1'b1);
      b = 8'h22;
      drive_bit(1'b0, 104);
      for (int i = 0; i < 8; i++) drive_bit(b[i], 104);
`ifdef UART_RX_PARITY_EN
      drive_bit(^b, 104);
`endif
      RxWire = 1'b1;
      repeat (56) @(negedge Clk);
      RxReady = 1'b1;
      @(posedge Clk);
      #1 chk1("sim_valid", RxValid, 1'b1);
      chk8("sim_data_new", RxDataOutput, 8'h22);
      @(negedge Clk) RxReady = 1'b0;
      repeat (47) @(negedge Clk);
      chkn("sim_no_ov", ov_cnt, o0);
      ack();
      chk1("sim_cleared", RxValid, 1'b0);

      // +/-4% bit period tolerance.
      f0 = fe_cnt;
      for (int pi = 0; pi < 2; pi++) begin
         for (int bi = 0; bi < 2; bi++) begin
            r0 = rise_cnt;
            repeat (2 * periods[pi]) @(negedge Clk);
            send_frame(pbytes[bi], periods[pi], 1'b1, 1'b1);
            chk8("tol_data", RxDataOutput, pbytes[bi]);
            chkn("tol_rise", rise_cnt, r0 + 1);
            ack();
         end
      end
      chkn("tol_no_fe", fe_cnt, f0);

      // Reset during data bit 4 of 8'hF0.
      r0 = rise_cnt;
      repeat (200) @(negedge Clk);
      b = 8'hF0;
      drive_bit(1'b0, 104);
      for (int i = 0; i < 4; i++) drive_bit(b[i], 104);
      RxWire = b[4];
      repeat (50) @(negedge Clk);
      Reset = 1'b0;
      #1 chk1("mid_rst_busy", RxBusy, 1'b0);
      chk8("mid_rst_data", RxDataOutput, 8'h00);
      repeat (5) @(negedge Clk);
      Reset = 1'b1;
      repeat (54) @(negedge Clk);
      for (int i = 5; i < 8; i++) drive_bit(b[i], 104);
      drive_bit(1'b1, 104);
      repeat (200) @(negedge Clk);
      chkn("mid_rst_no_byte", rise_cnt, r0);
      send_frame(8'h0F, 104, 1'b1, 1'b1);
      chkn("0f_only_byte", rise_cnt, r0 + 1);
      chk8("0f_data", RxDataOutput, 8'h0F);
      ack();

`ifdef UART_RX_PARITY_EN
      f0 = pe_cnt; r0 = rise_cnt;
      repeat (200) @(negedge Clk);
      send_frame(8'h07, 104, 1'b1, 1'b0);
      repeat (50) @(negedge Clk);
      chkn("par_err_pulse", pe_cnt, f0 + 1);
      chkn("par_no_valid", rise_cnt, r0);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
